// File: rtl/rp_decouple_pkg.sv
// Shared types and helpers for the RP shutdown/decouple controller.
package rp_decouple_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_DECOUPLED = 2'd2
  } state_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rp_decouple_ctrl_if.sv
// Stream and AXI address-channel bundle around the decouple controller.
// slave: the controller's view; master: the surrounding RP/static/PCIe side.
interface rp_decouple_ctrl_if
  import rp_decouple_pkg::*;
#(
  parameter int unsigned NUM_STREAMS  = 4,
  parameter int unsigned C_DATA_WIDTH = 128
);
  logic [NUM_STREAMS*C_DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_STREAMS-1:0]              s_axis_tlast;
  logic [NUM_STREAMS-1:0]              s_axis_tvalid;
  logic [NUM_STREAMS-1:0]              s_axis_tready;
  logic [NUM_STREAMS*C_DATA_WIDTH-1:0] m_axis_tdata;
  logic [NUM_STREAMS-1:0]              m_axis_tlast;
  logic [NUM_STREAMS-1:0]              m_axis_tvalid;
  logic [NUM_STREAMS-1:0]              m_axis_tready;
  logic s_arvalid, s_arready, m_arvalid, m_arready;
  logic s_awvalid, s_awready, m_awvalid, m_awready;
  logic rvalid, rready, rlast, bvalid, bready;

  modport slave (
    input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input  s_arvalid, m_arready, s_awvalid, m_awready,
    input  rvalid, rready, rlast, bvalid, bready,
    output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    output s_arready, m_arvalid, s_awready, m_awvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output s_arvalid, m_arready, s_awvalid, m_awready,
    output rvalid, rready, rlast, bvalid, bready,
    input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    input  s_arready, m_arvalid, s_awready, m_awvalid
  );
endinterface

// File: rtl/rp_outstanding_cnt.sv
// Saturating in-flight burst counter; simultaneous inc/dec leaves it unchanged.
module rp_outstanding_cnt
  import rp_decouple_pkg::*;
#(
  parameter int unsigned MAX = 16,
  parameter int unsigned W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full
);

  assign full = (count >= W'(MAX));

  // Count up on issue, down on completion, clamped to 0..MAX.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // A completion with nothing outstanding means the monitor taps are wrong.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || clr)
    !(dec && !inc && (count == '0)));

endmodule

// File: rtl/rp_decouple_ctrl.sv
// Shutdown/decouple controller between a reconfigurable partition and the
// static region. Optional drain timeout: define RP_DECOUPLE_TIMEOUT_EN.
//
//   state        | meaning
//   ST_ACTIVE    | RP coupled, traffic flows, new AR/AW allowed
//   ST_DRAIN     | finishing open frames and outstanding bursts, no new AR/AW
//   ST_DECOUPLED | RP quiescent, shutdown_ack high, streams gated
module rp_decouple_ctrl
  import rp_decouple_pkg::*;
#(
  parameter int unsigned NUM_STREAMS       = 4,
  parameter int unsigned C_DATA_WIDTH      = 128,
  parameter int unsigned C_MAX_OUTSTANDING = 16
`ifdef RP_DECOUPLE_TIMEOUT_EN
  , parameter int unsigned C_TIMEOUT       = 65535
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic shutdown_req,
  output logic shutdown_ack,
  output logic active,
  output logic timeout_flag,
  rp_decouple_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = cnt_w(C_MAX_OUTSTANDING);

  state_t state_q, state_d;
  logic active_q, ack_q;
  logic [NUM_STREAMS-1:0] in_frame_q, gate, s_rdy, s_hs;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;
  logic rd_full, wr_full, allow_ar, allow_aw;
  logic ar_hs, aw_hs, r_done, b_done, quiet, tmo_hit;

  // Zero-latency stream path; only valid/ready are gated.
  assign bus.m_axis_tdata  = bus.s_axis_tdata;
  assign bus.m_axis_tlast  = bus.s_axis_tlast;
  assign bus.s_axis_tready = s_rdy;

  for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_stream
    assign gate[g]              = (state_q != ST_ACTIVE) && !in_frame_q[g];
    assign s_rdy[g]             = bus.m_axis_tready[g] & ~gate[g];
    assign bus.m_axis_tvalid[g] = bus.s_axis_tvalid[g] & ~gate[g];
    assign s_hs[g]              = bus.s_axis_tvalid[g] & s_rdy[g];
  end

  // Track open frames: a non-last beat opens, a last beat closes.
  always_ff @(posedge clk) begin
    if (rst || tmo_hit) begin
      in_frame_q <= '0;
    end else begin
      in_frame_q <= (in_frame_q & ~s_hs) | (s_hs & ~bus.s_axis_tlast);
    end
  end

  assign allow_ar      = (state_q == ST_ACTIVE) && !rd_full;
  assign allow_aw      = (state_q == ST_ACTIVE) && !wr_full;
  assign bus.m_arvalid = bus.s_arvalid & allow_ar;
  assign bus.s_arready = bus.m_arready & allow_ar;
  assign bus.m_awvalid = bus.s_awvalid & allow_aw;
  assign bus.s_awready = bus.m_awready & allow_aw;
  assign ar_hs         = bus.s_arvalid & bus.m_arready & allow_ar;
  assign aw_hs         = bus.s_awvalid & bus.m_awready & allow_aw;
  assign r_done        = bus.rvalid & bus.rready & bus.rlast;
  assign b_done        = bus.bvalid & bus.bready;

  rp_outstanding_cnt #(.MAX(C_MAX_OUTSTANDING), .W(CNT_W)) u_rd_cnt (
    .clk(clk), .rst(rst), .clr(tmo_hit), .inc(ar_hs), .dec(r_done),
    .count(rd_cnt), .full(rd_full)
  );

  rp_outstanding_cnt #(.MAX(C_MAX_OUTSTANDING), .W(CNT_W)) u_wr_cnt (
    .clk(clk), .rst(rst), .clr(tmo_hit), .inc(aw_hs), .dec(b_done),
    .count(wr_cnt), .full(wr_full)
  );

  assign quiet = (in_frame_q == '0) && (rd_cnt == '0) && (wr_cnt == '0);

`ifdef RP_DECOUPLE_TIMEOUT_EN
  localparam int unsigned TMO_W = cnt_w(C_TIMEOUT);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_flag_q;

  // Fires on the C_TIMEOUT-th consecutive cycle spent in ST_DRAIN.
  assign tmo_hit      = (state_q == ST_DRAIN) && (tmo_cnt_q == TMO_W'(C_TIMEOUT - 1));
  assign timeout_flag = tmo_flag_q;

  // Drain watchdog and sticky flag; only rst clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if ((state_q == ST_DRAIN) && !tmo_hit) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      else                                   tmo_cnt_q <= '0;
      if (tmo_hit) tmo_flag_q <= 1'b1;
    end
  end
`else
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Next state; a dropped request in ST_DRAIN aborts even if already quiet.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (shutdown_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tmo_hit)            state_d = ST_DECOUPLED;
        else if (!shutdown_req) state_d = ST_ACTIVE;
        else if (quiet)         state_d = ST_DECOUPLED;
      end
      ST_DECOUPLED: begin
        if (!shutdown_req) state_d = ST_ACTIVE;
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // State register with status outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ACTIVE;
      active_q <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= (state_d == ST_ACTIVE);
      ack_q    <= (state_d == ST_DECOUPLED);
    end
  end

  assign active       = active_q;
  assign shutdown_ack = ack_q;

endmodule

// File: tb/tb_rp_decouple_ctrl.sv
// Self-checking bench for rp_decouple_ctrl: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the rules.
module tb_rp_decouple_ctrl;
  localparam int NS   = 4;
  localparam int DW   = 128;
  localparam int MAXO = 16;
  localparam int WB   = NS * DW;
  localparam int RUN  = 0;
  localparam int DRN  = 1;
  localparam int DEC  = 2;
`ifdef RP_DECOUPLE_TIMEOUT_EN
  localparam int TMO  = 100;
  int m_drain;
`endif

  logic clk = 1'b0;
  logic rst, shutdown_req, shutdown_ack, active, timeout_flag;

  rp_decouple_ctrl_if #(.NUM_STREAMS(NS), .C_DATA_WIDTH(DW)) bus ();

  rp_decouple_ctrl #(
    .NUM_STREAMS(NS), .C_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(MAXO)
`ifdef RP_DECOUPLE_TIMEOUT_EN
    , .C_TIMEOUT(TMO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .shutdown_req(shutdown_req),
    .shutdown_ack(shutdown_ack), .active(active), .timeout_flag(timeout_flag),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode of the decoupler, outstanding bursts, open frames.
  int             m_mode, m_rd, m_wr;
  logic [NS-1:0]  m_open;
  logic           m_active_r, m_ack_r, m_flag;

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = '0;
    bus.s_axis_tvalid = '0;
    bus.m_axis_tready = '1;
    bus.s_arvalid = 1'b0; bus.m_arready = 1'b1;
    bus.s_awvalid = 1'b0; bus.m_awready = 1'b1;
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    bus.bvalid = 1'b0; bus.bready = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = RUN; m_rd = 0; m_wr = 0; m_open = '0;
    m_active_r = 1'b1; m_ack_r = 1'b0; m_flag = 1'b0;
`ifdef RP_DECOUPLE_TIMEOUT_EN
    m_drain = 0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Check every output against the model for the current inputs, then
  // advance the model and the DUT by one clock. Called at the falling edge.
  task automatic tick();
    logic [NS-1:0] gate, e_rdy, e_vld, open_n;
    logic allow_ar, allow_aw, ar_hs, aw_hs, r_dn, b_dn, quiet;
    int nxt;
    #1;
    for (int i = 0; i < NS; i++) begin
      gate[i]  = (m_mode != RUN) && !m_open[i];
      e_rdy[i] = bus.m_axis_tready[i] && !gate[i];
      e_vld[i] = bus.s_axis_tvalid[i] && !gate[i];
    end
    allow_ar = (m_mode == RUN) && (m_rd < MAXO);
    allow_aw = (m_mode == RUN) && (m_wr < MAXO);
    chk("active",        active,            m_active_r);
    chk("shutdown_ack",  shutdown_ack,      m_ack_r);
    chk("timeout_flag",  timeout_flag,      m_flag);
    chk("s_axis_tready", bus.s_axis_tready, e_rdy);
    chk("m_axis_tvalid", bus.m_axis_tvalid, e_vld);
    chk("m_axis_tdata",  bus.m_axis_tdata,  bus.s_axis_tdata);
    chk("m_axis_tlast",  bus.m_axis_tlast,  bus.s_axis_tlast);
    chk("m_arvalid",     bus.m_arvalid,     bus.s_arvalid && allow_ar);
    chk("s_arready",     bus.s_arready,     bus.m_arready && allow_ar);
    chk("m_awvalid",     bus.m_awvalid,     bus.s_awvalid && allow_aw);
    chk("s_awready",     bus.s_awready,     bus.m_awready && allow_aw);

    for (int i = 0; i < NS; i++) begin
      open_n[i] = m_open[i];
      if (bus.s_axis_tvalid[i] && e_rdy[i]) open_n[i] = !bus.s_axis_tlast[i];
    end
    ar_hs = bus.s_arvalid && bus.m_arready && allow_ar;
    aw_hs = bus.s_awvalid && bus.m_awready && allow_aw;
    r_dn  = bus.rvalid && bus.rready && bus.rlast;
    b_dn  = bus.bvalid && bus.bready;
    quiet = (m_open == '0) && (m_rd == 0) && (m_wr == 0);

    nxt = m_mode;
    if (m_mode == RUN) begin
      if (shutdown_req) nxt = DRN;
    end else if (m_mode == DRN) begin
      if (!shutdown_req) nxt = RUN;
      else if (quiet)    nxt = DEC;
    end else begin
      if (!shutdown_req) nxt = RUN;
    end

    m_rd = m_rd + int'(ar_hs) - int'(r_dn);
    m_wr = m_wr + int'(aw_hs) - int'(b_dn);
    if (m_rd < 0) m_rd = 0;
    if (m_rd > MAXO) m_rd = MAXO;
    if (m_wr < 0) m_wr = 0;
    if (m_wr > MAXO) m_wr = MAXO;
    m_open = open_n;

`ifdef RP_DECOUPLE_TIMEOUT_EN
    if ((m_mode == DRN) && (m_drain + 1 == TMO)) begin
      nxt = DEC; m_open = '0; m_rd = 0; m_wr = 0; m_flag = 1'b1;
    end
    m_drain = ((nxt == DRN) && (m_mode == DRN)) ? m_drain + 1 : 0;
`endif
    m_mode     = nxt;
    m_active_r = (nxt == RUN);
    m_ack_r    = (nxt == DEC);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    shutdown_req = 1'b1;
    set_idle();
    model_reset();
    // Request held through reset is only seen after release.
    do_reset();
    chk("rst_active", active, 1);
    chk("rst_ack", shutdown_ack, 0);
    chk("rst_rd_cnt", dut.rd_cnt, 0);
    tick();
    chk("drain_active", active, 0);
    chk("drain_tready", bus.s_axis_tready, 0);
    chk("drain_ack", shutdown_ack, 0);
    tick();
    chk("idle_ack_2cyc", shutdown_ack, 1);
    shutdown_req = 1'b0;
    tick();
    chk("release_active", active, 1);

    // One-cycle pulse: drain then abort, never acked.
    shutdown_req = 1'b1;
    tick();
    shutdown_req = 1'b0;
    tick();
    chk("pulse_active", active, 1);
    chk("pulse_ack", shutdown_ack, 0);

    // Stream 2 mid-frame when the request arrives.
    for (int b = 0; b < 8; b++) begin
      for (int w = 0; w < WB / 32; w++) bus.s_axis_tdata[w*32 +: 32] = $urandom;
      bus.s_axis_tvalid[2] = 1'b1;
      bus.s_axis_tlast[2]  = (b == 7);
      if (b == 3) shutdown_req = 1'b1;
      #1;
      chk("s2_beat_pass", bus.m_axis_tvalid[2], 1);
      tick();
    end
    bus.s_axis_tlast[2] = 1'b0;
    #1;
    chk("s2_new_frame_blocked", bus.s_axis_tready[2], 0);
    chk("s2_ack_early", shutdown_ack, 0);
    tick();
    chk("s2_ack", shutdown_ack, 1);
    chk("s2_still_blocked", bus.m_axis_tvalid[2], 0);
    shutdown_req = 1'b0;
    bus.s_axis_tvalid[2] = 1'b0;
    tick();

    // Three reads outstanding at shutdown.
    set_idle();
    bus.s_arvalid = 1'b1;
    repeat (3) tick();
    bus.s_arvalid = 1'b0;
    shutdown_req  = 1'b1;
    tick();
    bus.s_arvalid = 1'b1;
    #1;
    chk("ar_blocked_ready", bus.s_arready, 0);
    chk("ar_blocked_valid", bus.m_arvalid, 0);
    for (int k = 0; k < 3; k++) begin
      chk("ar_ack_pending", shutdown_ack, 0);
      bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b0;
      tick();
      bus.rlast = 1'b1;
      tick();
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    chk("ar_ack_early", shutdown_ack, 0);
    tick();
    chk("ar_ack", shutdown_ack, 1);
    shutdown_req = 1'b0;
    set_idle();
    tick();

    // Write limit back-pressure in ACTIVE.
    bus.s_awvalid = 1'b1;
    repeat (16) tick();
    #1;
    chk("aw_full_ready", bus.s_awready, 0);
    chk("aw_full_valid", bus.m_awvalid, 0);
    chk("aw_full_active", active, 1);
    bus.s_awvalid = 1'b0;
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.bvalid = 1'b0;
    bus.s_awvalid = 1'b1;
    bus.m_awready = 1'b0;
    #1;
    chk("aw_follow_lo", bus.s_awready, 0);
    bus.m_awready = 1'b1;
    #1;
    chk("aw_follow_hi", bus.s_awready, 1);
    tick();
    bus.s_awvalid = 1'b0;
    bus.bvalid = 1'b1;
    repeat (16) tick();
    bus.bvalid = 1'b0;
    chk("wr_cnt_drained", dut.wr_cnt, 0);

    // Simultaneous issue and completion keeps the count.
    shutdown_req = 1'b0;
    set_idle();
    do_reset();
    bus.s_arvalid = 1'b1;
    repeat (5) tick();
    chk("rd_cnt_5", dut.rd_cnt, 5);
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
    tick();
    chk("rd_cnt_same_cycle", dut.rd_cnt, 5);
    set_idle();

    // Reset mid-DRAIN, then reset in DECOUPLED.
    shutdown_req = 1'b1;
    repeat (3) tick();
    chk("stuck_drain_ack", shutdown_ack, 0);
    do_reset();
    chk("rst_mid_active", active, 1);
    chk("rst_mid_rd_cnt", dut.rd_cnt, 0);
    repeat (2) tick();
    chk("post_rst_ack", shutdown_ack, 1);
    shutdown_req = 1'b0;
    do_reset();
    chk("rst_dec_active", active, 1);
    chk("rst_dec_ack", shutdown_ack, 0);

    // Randomized traffic with a wandering shutdown request.
    for (int n = 0; n < 3000; n++) begin
      for (int w = 0; w < WB / 32; w++) bus.s_axis_tdata[w*32 +: 32] = $urandom;
      bus.s_axis_tvalid = NS'($urandom);
      bus.s_axis_tlast  = NS'($urandom & $urandom);
      bus.m_axis_tready = NS'($urandom | $urandom);
      bus.s_arvalid = 1'($urandom); bus.m_arready = 1'($urandom);
      bus.s_awvalid = 1'($urandom); bus.m_awready = 1'($urandom);
      bus.rvalid = 1'($urandom); bus.rready = 1'($urandom);
      bus.rlast  = (m_rd > 0) ? 1'($urandom) : 1'b0;
      bus.bvalid = (m_wr > 0) ? 1'($urandom) : 1'b0;
      bus.bready = 1'($urandom);
      if ($urandom_range(0, 19) == 0) shutdown_req = !shutdown_req;
      tick();
    end

`ifdef RP_DECOUPLE_TIMEOUT_EN
    // Stuck frame forces DECOUPLED after the drain timeout.
    shutdown_req = 1'b0;
    set_idle();
    do_reset();
    bus.s_axis_tvalid[0] = 1'b1;
    tick();
    bus.s_axis_tvalid[0] = 1'b0;
    shutdown_req = 1'b1;
    repeat (100) tick();
    chk("tmo_ack_early", shutdown_ack, 0);
    tick();
    chk("tmo_ack", shutdown_ack, 1);
    chk("tmo_flag_set", timeout_flag, 1);
    shutdown_req = 1'b0;
    tick();
    chk("tmo_active", active, 1);
    chk("tmo_flag_sticky", timeout_flag, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
